// File: rtl/aux_adc_cal_pkg.sv
// Shared types and constants for the auxiliary ADC calibration sequencer.
// Holds the state encoding, the calMode codes and the default counter widths.
package aux_adc_cal_pkg;

   localparam int SETTLE_W_DEF = 8;
   localparam int PHASE_W_DEF  = 6;

   localparam logic [1:0] CAL_NONE = 2'b00;
   localparam logic [1:0] CAL_P1   = 2'b01;
   localparam logic [1:0] CAL_P2   = 2'b10;
   localparam logic [1:0] CAL_P3   = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PWRUP = 3'd1,
      ST_SHORT = 3'd2,
      ST_CAL1  = 3'd3,
      ST_CAL2  = 3'd4,
      ST_CAL3  = 3'd5,
      ST_RUN   = 3'd6
   } cal_state_e;

   function automatic int max_w(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic is_busy_state(input cal_state_e s);
      logic r;
      case (s)
         ST_PWRUP, ST_SHORT, ST_CAL1, ST_CAL2, ST_CAL3: r = 1'b1;
         default:                                       r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/aux_cal_timer.sv
// Loadable down-counter shared by the power-up settle and every calibration phase.
// A load of N makes expire_o rise after max(N,1)-1 further cycles, so the state lasts max(N,1) cycles.
module aux_cal_timer #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         expire_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: load max(N,1)-1, otherwise count down and park at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         if (load_val_i == '0) begin
            cnt_d = '0;
         end else begin
            cnt_d = load_val_i - W'(1);
         end
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/aux_adc_cal_seq.sv
// Power-up and calibration sequencer for the aux ADC I-channels CHI1/CHI2.
// Outputs are registered from the next-state decode so they change on the start edge itself.
module aux_adc_cal_seq #(
   parameter int SETTLE_W = aux_adc_cal_pkg::SETTLE_W_DEF,
   parameter int PHASE_W  = aux_adc_cal_pkg::PHASE_W_DEF
) (
   input  logic                PClkxCI,
   input  logic                PResetxRBI,
   input  logic                cal_start_i,
   input  logic                abort_i,
   input  logic [1:0]          ch_mask_i,
   input  logic [SETTLE_W-1:0] settle_cycles_i,
   input  logic [PHASE_W-1:0]  phase_cycles_i,
   input  logic                iqmux_cfg_i,
   output logic                CHI_adcEn_muxed,
   output logic                CHI1_chEn_muxed,
   output logic                CHI2_chEn_muxed,
   output logic [1:0]          CHI1_calMode_muxed,
   output logic [1:0]          CHI2_calMode_muxed,
   output logic                CHI1_short_muxed,
   output logic                CHI2_short_muxed,
   output logic                adc_iqmuxEn_i_muxed,
   output logic                busy_o,
   output logic                done_o,
   output logic                err_o
);
   import aux_adc_cal_pkg::*;

   localparam int TW = max_w(SETTLE_W, PHASE_W);

   cal_state_e          state_q, state_d;
   logic                ch_idx_q, ch_idx_d;
   logic [1:0]          mask_q, mask_d;
   logic [PHASE_W-1:0]  phase_q, phase_d;

   logic                adc_en_q, adc_en_d;
   logic                c1_en_q, c1_en_d, c2_en_q, c2_en_d;
   logic                c1_short_q, c1_short_d, c2_short_q, c2_short_d;
   logic [1:0]          c1_cal_q, c1_cal_d, c2_cal_q, c2_cal_d;
   logic                iqmux_q, iqmux_d;
   logic                busy_q, busy_d, done_q, done_d, err_q, err_d;

   logic                tmr_load_s;
   logic [TW-1:0]       tmr_val_s;
   logic                tmr_exp_s;
   logic                idle_or_run_s;
   logic                act_en_s, act_short_s;
   logic [1:0]          act_cal_s;

   aux_cal_timer #(.W(TW)) u_timer (
      .clk_i      (PClkxCI),
      .rst_ni     (PResetxRBI),
      .load_i     (tmr_load_s),
      .load_val_i (tmr_val_s),
      .expire_o   (tmr_exp_s)
   );

   // State, channel index, latched configuration and registered outputs
   always_ff @(posedge PClkxCI or negedge PResetxRBI) begin
      if (!PResetxRBI) begin
         state_q    <= ST_IDLE;
         ch_idx_q   <= 1'b0;
         mask_q     <= 2'b00;
         phase_q    <= '0;
         adc_en_q   <= 1'b0;
         c1_en_q    <= 1'b0;
         c2_en_q    <= 1'b0;
         c1_short_q <= 1'b0;
         c2_short_q <= 1'b0;
         c1_cal_q   <= CAL_NONE;
         c2_cal_q   <= CAL_NONE;
         iqmux_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ch_idx_q   <= ch_idx_d;
         mask_q     <= mask_d;
         phase_q    <= phase_d;
         adc_en_q   <= adc_en_d;
         c1_en_q    <= c1_en_d;
         c2_en_q    <= c2_en_d;
         c1_short_q <= c1_short_d;
         c2_short_q <= c2_short_d;
         c1_cal_q   <= c1_cal_d;
         c2_cal_q   <= c2_cal_d;
         iqmux_q    <= iqmux_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign idle_or_run_s = (state_q == ST_IDLE) || (state_q == ST_RUN);

   // Next state; a start from RUN skips power-up and times its first phase from the live input
   always_comb begin
      state_d    = state_q;
      ch_idx_d   = ch_idx_q;
      mask_d     = mask_q;
      phase_d    = phase_q;
      tmr_load_s = 1'b0;
      tmr_val_s  = '0;
      err_d      = 1'b0;
      if (abort_i) begin
         state_d = ST_IDLE;
      end else if (cal_start_i && idle_or_run_s) begin
         if (ch_mask_i != 2'b00) begin
            mask_d     = ch_mask_i;
            phase_d    = phase_cycles_i;
            ch_idx_d   = ~ch_mask_i[0];
            tmr_load_s = 1'b1;
            if (state_q == ST_IDLE) begin
               state_d   = ST_PWRUP;
               tmr_val_s = TW'(settle_cycles_i);
            end else begin
               state_d   = ST_SHORT;
               tmr_val_s = TW'(phase_cycles_i);
            end
         end else begin
            err_d = 1'b1;
         end
      end else if (tmr_exp_s) begin
         tmr_val_s = TW'(phase_q);
         case (state_q)
            ST_PWRUP: begin state_d = ST_SHORT; tmr_load_s = 1'b1; end
            ST_SHORT: begin state_d = ST_CAL1;  tmr_load_s = 1'b1; end
            ST_CAL1:  begin state_d = ST_CAL2;  tmr_load_s = 1'b1; end
            ST_CAL2:  begin state_d = ST_CAL3;  tmr_load_s = 1'b1; end
            ST_CAL3: begin
               if (!ch_idx_q && mask_q[1]) begin
                  state_d    = ST_SHORT;
                  ch_idx_d   = 1'b1;
                  tmr_load_s = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_IDLE, ST_RUN: state_d = state_q;
            default:         state_d = ST_IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Output decode from the next state, steering the active-channel controls to one channel
   always_comb begin
      act_en_s    = 1'b0;
      act_short_s = 1'b0;
      act_cal_s   = CAL_NONE;
      adc_en_d    = (state_d != ST_IDLE);
      c1_en_d     = 1'b0;
      c2_en_d     = 1'b0;
      c1_short_d  = 1'b0;
      c2_short_d  = 1'b0;
      c1_cal_d    = CAL_NONE;
      c2_cal_d    = CAL_NONE;
      iqmux_d     = 1'b0;
      case (state_d)
         ST_SHORT: begin act_en_s = 1'b1; act_short_s = 1'b1; act_cal_s = CAL_NONE; end
         ST_CAL1:  begin act_en_s = 1'b1; act_cal_s = CAL_P1; end
         ST_CAL2:  begin act_en_s = 1'b1; act_cal_s = CAL_P2; end
         ST_CAL3:  begin act_en_s = 1'b1; act_cal_s = CAL_P3; end
         ST_RUN: begin
            c1_en_d = mask_d[0];
            c2_en_d = mask_d[1];
            iqmux_d = iqmux_cfg_i;
         end
         default: act_en_s = 1'b0;
      endcase
      if (!ch_idx_d) begin
         c1_en_d    = c1_en_d | act_en_s;
         c1_short_d = act_short_s;
         c1_cal_d   = act_cal_s;
      end else begin
         c2_en_d    = c2_en_d | act_en_s;
         c2_short_d = act_short_s;
         c2_cal_d   = act_cal_s;
      end
      busy_d = is_busy_state(state_d);
      done_d = (state_d == ST_RUN) && (state_q != ST_RUN);
   end

   assign CHI_adcEn_muxed     = adc_en_q;
   assign CHI1_chEn_muxed     = c1_en_q;
   assign CHI2_chEn_muxed     = c2_en_q;
   assign CHI1_calMode_muxed  = c1_cal_q;
   assign CHI2_calMode_muxed  = c2_cal_q;
   assign CHI1_short_muxed    = c1_short_q;
   assign CHI2_short_muxed    = c2_short_q;
   assign adc_iqmuxEn_i_muxed = iqmux_q;
   assign busy_o              = busy_q;
   assign done_o              = done_q;
   assign err_o               = err_q;

endmodule
